mux2_arbiter: RTL and testbench

MUX2_ARBITER -- requirements
Module: mux2_arbiter

---
 rtl/mux2_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux2_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_arbiter
//
// Purpose:
//   Sequences a two-input mux (mux2) between two requesters. One requester
//   owns the mux at a time. The owner keeps it for up to BURST transfers
//   while the other requester is waiting, then ownership passes across with
//   no idle cycle in between. A 1-bit priority pointer breaks ties when both
//   requests arrive together in IDLE.
//
// Parameters:
//   BURST      maximum back-to-back transfers for one owner while the other
//              requester waits (BURST >= 1)
//   TpdOr      OR-gate delay of the sequenced mux2
//   TpdNot     inverter delay of the sequenced mux2; the clock period must be
//              at least 2*TpdNot + 2*TpdOr + 1 so z settles after sel moves
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req0       requester 0 has a word on mux2 input d0
//   req1       requester 1 has a word on mux2 input d1
//   ack0       a requester-0 transfer completes this cycle
//   ack1       a requester-1 transfer completes this cycle
//   sel        registered mux2 select (0 = d0, 1 = d1)
//   out_valid  mux2 output z carries a valid word this cycle
//   out_ready  downstream consumer accepts z this cycle
// ---------------------------------------------------------------------------
module mux2_arbiter #(
    parameter int BURST  = 4,
    parameter int TpdOr  = 1,
    parameter int TpdNot = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic out_ready,
    output logic ack0,
    output logic ack1,
    output logic sel,
    output logic out_valid
);

    localparam int CntW = $clog2(BURST + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BURST - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    // Reject parameter sets that cannot describe a real arbiter / mux pair.
    if (BURST < 1 || TpdOr < 0 || TpdNot < 0) begin : g_bad_params
        $error("mux2_arbiter: BURST must be >= 1 and mux delays non-negative");
    end

    logic [1:0]      state_q, state_d;
    logic            sel_q, sel_d;
    logic            prio_q, prio_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic ownReq;
    logic othReq;
    logic ownerId;
    logic xfer;
    logic lastBeat;

    // Owner-relative view of the requests, so both OWN states share one
    // transition rule. In IDLE these values are unused.
    assign ownerId  = (state_q == OWN1);
    assign ownReq   = ownerId ? req1 : req0;
    assign othReq   = ownerId ? req0 : req1;

    assign out_valid = ((state_q == OWN0) & req0) | ((state_q == OWN1) & req1);
    assign xfer      = out_valid & out_ready;
    assign ack0      = xfer & (state_q == OWN0);
    assign ack1      = xfer & (state_q == OWN1);
    assign sel       = sel_q;

    // The transfer happening now is the last one this owner may take in a row.
    assign lastBeat  = xfer & (cnt_q == LastCnt);

    // Next-state logic. A hand-over (ownership moves directly to the other
    // requester) wins over going idle, which wins over a burst restart.
    // Without a transfer nothing moves while the owner still requests, which
    // gives the backpressure hold for free.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        state_d = prio_q ? OWN1 : OWN0;
                        sel_d   = prio_q;
                    end else begin
                        state_d = req1 ? OWN1 : OWN0;
                        sel_d   = req1;
                    end
                    cnt_d = '0;
                end
            end
            OWN0, OWN1: begin
                if ((!ownReq || lastBeat) && othReq) begin
                    state_d = ownerId ? OWN0 : OWN1;
                    sel_d   = ~ownerId;
                    prio_d  = ~ownerId;
                    cnt_d   = '0;
                end else if (!ownReq && !othReq) begin
                    state_d = IDLE;
                    prio_d  = ~ownerId;
                end else if (lastBeat) begin
                    cnt_d = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears everything at once, which also forces
    // out_valid and both acks low without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_arbiter
//
// Purpose:
//   Directed bench for mux2_arbiter. Instance dutA uses BURST = 4, instance
//   dutB uses BURST = 1. Inputs change 1 time unit after a rising edge and
//   outputs are compared 1 time unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_mux2_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic req0, req1, outReady;
    logic ack0, ack1, sel, outValid;
    logic bReq0, bReq1, bReady;
    logic bAck0, bAck1, bSel, bValid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(.BURST(4), .TpdOr(1), .TpdNot(1)) dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .out_ready (outReady),
        .ack0      (ack0),
        .ack1      (ack1),
        .sel       (sel),
        .out_valid (outValid)
    );

    mux2_arbiter #(.BURST(1), .TpdOr(1), .TpdNot(1)) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (bReq0),
        .req1      (bReq1),
        .out_ready (bReady),
        .ack0      (bAck0),
        .ack1      (bAck1),
        .sel       (bSel),
        .out_valid (bValid)
    );

    // One comparison: count it, and on a difference count and report it.
    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Compare one cycle of dutA outputs, then move to just after the next edge.
    task automatic applyStimulus(input string tag, input logic v, input logic a0,
                                 input logic a1, input logic s);
        #1;
        checkOutput({tag, ".valid"}, outValid, v);
        checkOutput({tag, ".ack0"}, ack0, a0);
        checkOutput({tag, ".ack1"}, ack1, a1);
        checkOutput({tag, ".sel"}, sel, s);
        @(posedge clk);
        #1;
    endtask

    // Same as applyStimulus, for the BURST = 1 instance.
    task automatic applyStimulusB(input string tag, input logic v, input logic a0,
                                  input logic a1, input logic s);
        #1;
        checkOutput({tag, ".valid"}, bValid, v);
        checkOutput({tag, ".ack0"}, bAck0, a0);
        checkOutput({tag, ".ack1"}, bAck1, a1);
        checkOutput({tag, ".sel"}, bSel, s);
        @(posedge clk);
        #1;
    endtask

    // Pulse reset across one edge, checking the outputs while it is held.
    task automatic doReset(input string tag);
        rst_n    = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        outReady = 1'b0;
        bReq0    = 1'b0;
        bReq1    = 1'b0;
        bReady   = 1'b0;
        #1;
        checkOutput({tag, ".rst.valid"}, outValid, 1'b0);
        checkOutput({tag, ".rst.ack0"}, ack0, 1'b0);
        checkOutput({tag, ".rst.ack1"}, ack1, 1'b0);
        checkOutput({tag, ".rst.sel"}, sel, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- Scenario 2: single requester streaming ----------
        doReset("s2");
        req0 = 1'b1;
        outReady = 1'b1;
        applyStimulus("s2.idle", 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("s2.beat%0d", i), 1, 1, 0, 0);
        end
        // Leaving OWN0 for IDLE hands priority to requester 1.
        req0 = 1'b0;
        applyStimulus("s2.drop", 0, 0, 0, 0);
        req0 = 1'b1;
        req1 = 1'b1;
        applyStimulus("s2.tie", 0, 0, 0, 0);
        applyStimulus("s2.win1", 1, 0, 1, 1);

        // ---------------- Scenario 1: reset between edges in OWN1 ---------
        doReset("s1");
        req1 = 1'b1;
        outReady = 1'b0;
        applyStimulus("s1.idle", 0, 0, 0, 0);
        outReady = 1'b1;
        #1;
        checkOutput("s1.pre.valid", outValid, 1'b1);
        checkOutput("s1.pre.ack1", ack1, 1'b1);
        checkOutput("s1.pre.sel", sel, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s1.mid.sel", sel, 1'b0);
        checkOutput("s1.mid.valid", outValid, 1'b0);
        checkOutput("s1.mid.ack1", ack1, 1'b0);
        @(posedge clk);
        #1;

        // ---------------- Scenario 3: both requesting, BURST = 4 ----------
        doReset("s3");
        req0 = 1'b1;
        req1 = 1'b1;
        outReady = 1'b1;
        applyStimulus("s3.idle", 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            logic owner;
            owner = ((i / 4) % 2) == 1;
            applyStimulus($sformatf("s3.beat%0d", i), 1, !owner, owner, owner);
        end

        // ---------------- Scenario 4: backpressure in OWN0 ----------------
        doReset("s4");
        req0 = 1'b1;
        outReady = 1'b0;
        applyStimulus("s4.idle", 0, 0, 0, 0);
        // Requester 1 waits throughout, so a counter that moved during the
        // stall would hand over early.
        req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("s4.stall%0d", i), 1, 0, 0, 0);
        end
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("s4.go%0d", i), 1, 1, 0, 0);
        end
        applyStimulus("s4.handover", 1, 0, 1, 1);

        // ---------------- Scenario 5: owner drops, other takes over -------
        doReset("s5");
        req0 = 1'b1;
        outReady = 1'b1;
        applyStimulus("s5.idle", 0, 0, 0, 0);
        applyStimulus("s5.own0", 1, 1, 0, 0);
        req0 = 1'b0;
        req1 = 1'b1;
        applyStimulus("s5.drop0", 0, 0, 0, 0);
        applyStimulus("s5.own1", 1, 0, 1, 1);
        req1 = 1'b0;
        applyStimulus("s5.drop1", 0, 0, 0, 1);
        req0 = 1'b1;
        req1 = 1'b1;
        applyStimulus("s5.tie", 0, 0, 0, 1);
        applyStimulus("s5.win0", 1, 1, 0, 0);

        // ---------------- Scenario 6: BURST = 1 alternation ---------------
        doReset("s6");
        bReq0 = 1'b1;
        bReq1 = 1'b1;
        bReady = 1'b1;
        applyStimulusB("s6.idle", 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            logic owner;
            owner = (i % 2) == 1;
            applyStimulusB($sformatf("s6.beat%0d", i), 1, !owner, owner, owner);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
